// File: rtl/ram_arbiter_pkg.sv
// Shared types for the RAM arbiter: FSM states, RAM owner codes, default widths.
package ram_arbiter_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_BOOT    = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_RELEASE = 2'd2,
    ST_RUN     = 2'd3
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_LD   = 2'd2
  } owner_e;

endpackage

// File: rtl/ram_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear; flags when the ceiling is reached.
module ram_arbiter_sat_counter #(
  parameter int MAX = 255,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_sat
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] r_cnt;

  // Count register: clear dominates increment, increment stops at the ceiling
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != MAX_V)) begin
      r_cnt <= r_cnt + W'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_sat = (r_cnt == MAX_V);

endmodule

// File: rtl/ram_arbiter.sv
// Single-port RAM arbiter between the CPU control unit and the boot/debug loader,
// including the boot hand-over sequence that holds the CPU in reset while loading.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int ADDR_W        = ADDR_W_DEF,
  parameter int DATA_W        = DATA_W_DEF,
  parameter bit BOOT_ON_RESET = 1'b1,
  parameter int STARVE_MAX    = 255
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_boot_en,
  input  logic              i_boot_done,
  output logic              o_cpu_reset,
  input  logic              i_cpu_rd,
  input  logic              i_cpu_wr,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  input  logic [DATA_W-1:0] i_cpu_wdata,
  output logic [DATA_W-1:0] o_cpu_rdata,
  input  logic              i_ld_req,
  input  logic              i_ld_we,
  input  logic [ADDR_W-1:0] i_ld_addr,
  input  logic [DATA_W-1:0] i_ld_wdata,
  output logic              o_ld_ack,
  output logic [DATA_W-1:0] o_ld_rdata,
  output logic              o_ram_re,
  output logic              o_ram_we,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [DATA_W-1:0] o_ram_wdata,
  input  logic [DATA_W-1:0] i_ram_rdata,
  output logic [1:0]        o_owner,
  output logic              o_ld_starved,
  output logic              o_proto_err
);

  localparam arb_state_e RST_STATE = BOOT_ON_RESET ? ST_BOOT : ST_RUN;
  localparam int         STARVE_W  = $clog2(STARVE_MAX + 1);

  arb_state_e        r_state;
  arb_state_e        w_state_nxt;
  logic              r_ld_pend;
  logic              r_ld_rd;
  logic              r_boot_en_q;
  logic              r_proto_err;
  logic [DATA_W-1:0] r_ld_rdata;
  logic              w_boot_edge;
  logic              w_cpu_acc;
  logic              w_ld_window;
  logic              w_accept;
  logic              w_boot_entry;
  logic              w_starve_inc;
  owner_e            w_owner;

  // Commands are gated by the reset pin so the RAM sees nothing while reset is held
  assign w_boot_edge  = i_boot_en & ~r_boot_en_q;
  assign w_cpu_acc    = i_rst_n & (r_state == ST_RUN) & (i_cpu_rd | i_cpu_wr);
  assign w_ld_window  = (r_state == ST_BOOT) | (r_state == ST_RUN);
  assign w_accept     = i_rst_n & i_ld_req & ~r_ld_pend & w_ld_window & ~w_cpu_acc;
  assign w_boot_entry = (r_state == ST_RUN) & w_boot_edge;
  assign w_starve_inc = i_ld_req & ~r_ld_pend & w_cpu_acc;

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= RST_STATE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; an outstanding loader access always acks in the first DRAIN cycle
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_BOOT: begin
        if (i_boot_done) w_state_nxt = ST_DRAIN;
        else             w_state_nxt = ST_BOOT;
      end
      ST_DRAIN:   w_state_nxt = ST_RELEASE;
      ST_RELEASE: w_state_nxt = ST_RUN;
      ST_RUN: begin
        if (w_boot_edge) w_state_nxt = ST_BOOT;
        else             w_state_nxt = ST_RUN;
      end
      default:    w_state_nxt = RST_STATE;
    endcase
  end

  // Output logic: CPU reset decode and this cycle's RAM command (CPU first, write wins)
  always_comb begin
    o_cpu_reset = (r_state != ST_RUN);
    w_owner     = OWN_NONE;
    o_ram_re    = 1'b0;
    o_ram_we    = 1'b0;
    o_ram_addr  = '0;
    o_ram_wdata = '0;
    if (w_cpu_acc) begin
      w_owner     = OWN_CPU;
      o_ram_we    = i_cpu_wr;
      o_ram_re    = i_cpu_rd & ~i_cpu_wr;
      o_ram_addr  = i_cpu_addr;
      o_ram_wdata = i_cpu_wdata;
    end else if (w_accept) begin
      w_owner     = OWN_LD;
      o_ram_we    = i_ld_we;
      o_ram_re    = ~i_ld_we;
      o_ram_addr  = i_ld_addr;
      o_ram_wdata = i_ld_wdata;
    end else begin
      w_owner     = OWN_NONE;
    end
  end

  // Loader completion, boot_en edge history and sticky protocol error
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ld_pend   <= 1'b0;
      r_ld_rd     <= 1'b0;
      r_ld_rdata  <= '0;
      r_boot_en_q <= 1'b0;
      r_proto_err <= 1'b0;
    end else begin
      r_ld_pend   <= w_accept;
      r_boot_en_q <= i_boot_en;
      if (w_accept) r_ld_rd <= ~i_ld_we;
      else          r_ld_rd <= r_ld_rd;
      if (r_ld_pend && r_ld_rd) r_ld_rdata <= i_ram_rdata;
      else                      r_ld_rdata <= r_ld_rdata;
      if (w_cpu_acc && i_cpu_rd && i_cpu_wr) r_proto_err <= 1'b1;
      else                                   r_proto_err <= r_proto_err;
    end
  end

  ram_arbiter_sat_counter #(
    .MAX (STARVE_MAX),
    .W   (STARVE_W)
  ) u_starve (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_inc   (w_starve_inc),
    .i_clr   (w_accept | w_boot_entry),
    .o_sat   (o_ld_starved)
  );

  // Read data is presented in the ack cycle straight from the RAM, then held
  assign o_ld_ack    = r_ld_pend;
  assign o_ld_rdata  = (r_ld_pend & r_ld_rd) ? i_ram_rdata : r_ld_rdata;
  assign o_cpu_rdata = i_ram_rdata;
  assign o_owner     = w_owner;
  assign o_proto_err = r_proto_err;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed boot/run scenarios plus a random run phase,
// all compared cycle by cycle against a behavioural model of the arbitration rules.
module tb_ram_arbiter;

  localparam int AW   = 16;
  localparam int DW   = 16;
  localparam int SMAX = 255;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b1;
  logic          boot_en, boot_done, cpu_rd, cpu_wr, ld_req, ld_we;
  logic [AW-1:0] cpu_addr, ld_addr;
  logic [DW-1:0] cpu_wdata, ld_wdata;
  logic          o_cpu_reset, o_ld_ack, o_ram_re, o_ram_we, o_ld_starved, o_proto_err;
  logic [DW-1:0] o_cpu_rdata, o_ld_rdata, o_ram_wdata;
  logic [AW-1:0] o_ram_addr;
  logic [1:0]    o_owner;
  logic [DW-1:0] ram_rdata = 16'h0000;
  logic [DW-1:0] ram_mem [0:255] = '{default: 16'h0000};

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ram_arbiter dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_boot_en(boot_en), .i_boot_done(boot_done),
    .o_cpu_reset(o_cpu_reset), .i_cpu_rd(cpu_rd), .i_cpu_wr(cpu_wr),
    .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata), .o_cpu_rdata(o_cpu_rdata),
    .i_ld_req(ld_req), .i_ld_we(ld_we), .i_ld_addr(ld_addr), .i_ld_wdata(ld_wdata),
    .o_ld_ack(o_ld_ack), .o_ld_rdata(o_ld_rdata), .o_ram_re(o_ram_re), .o_ram_we(o_ram_we),
    .o_ram_addr(o_ram_addr), .o_ram_wdata(o_ram_wdata), .i_ram_rdata(ram_rdata),
    .o_owner(o_owner), .o_ld_starved(o_ld_starved), .o_proto_err(o_proto_err)
  );

  // Synchronous RAM seen by the arbiter (bench addresses stay below 0x100)
  always @(posedge clk) begin
    if (o_ram_we) ram_mem[o_ram_addr[7:0]] <= o_ram_wdata;
    if (o_ram_re) ram_rdata <= ram_mem[o_ram_addr[7:0]];
  end

  // Behavioural model of the arbitration rules
  string         m_mode;
  bit            m_pend, m_pend_rd, m_proto, m_boot_en_q, m_rdv;
  int            m_starve;
  logic [DW-1:0] m_rdval, m_ld_rdata;
  logic [DW-1:0] exp_mem [int];
  bit            c_cpu, c_acc, c_re, c_we;
  logic [1:0]    c_own;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_wd;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
    return exp_mem.exists(int'(a)) ? exp_mem[int'(a)] : 16'h0000;
  endfunction

  task automatic model_reset();
    m_mode = "BOOT"; m_pend = 1'b0; m_pend_rd = 1'b0; m_proto = 1'b0;
    m_boot_en_q = 1'b0; m_rdv = 1'b0; m_starve = 0; m_ld_rdata = 16'h0000;
  endtask

  task automatic check_cycle();
    bit in_run;
    in_run = (m_mode == "RUN");
    c_cpu  = in_run && (cpu_rd || cpu_wr);
    c_acc  = !c_cpu && ld_req && !m_pend && (m_mode == "BOOT" || in_run);
    c_own = 2'd0; c_re = 1'b0; c_we = 1'b0; c_addr = 16'h0000; c_wd = 16'h0000;
    if (c_cpu) begin
      c_own = 2'd1; c_we = cpu_wr; c_re = !cpu_wr; c_addr = cpu_addr; c_wd = cpu_wdata;
    end else if (c_acc) begin
      c_own = 2'd2; c_we = ld_we; c_re = !ld_we; c_addr = ld_addr; c_wd = ld_wdata;
    end
    chk("owner",     32'(o_owner),      32'(c_own));
    chk("ram_re",    32'(o_ram_re),     32'(c_re));
    chk("ram_we",    32'(o_ram_we),     32'(c_we));
    chk("ram_addr",  32'(o_ram_addr),   32'(c_addr));
    chk("ram_wdata", 32'(o_ram_wdata),  32'(c_wd));
    chk("ld_ack",    32'(o_ld_ack),     32'(m_pend));
    chk("ld_rdata",  32'(o_ld_rdata),   32'((m_pend && m_pend_rd) ? m_rdval : m_ld_rdata));
    chk("cpu_reset", 32'(o_cpu_reset),  32'(!in_run));
    chk("starved",   32'(o_ld_starved), 32'(m_starve == SMAX));
    chk("proto_err", 32'(o_proto_err),  32'(m_proto));
    if (m_rdv) chk("cpu_rdata", 32'(o_cpu_rdata), 32'(m_rdval));
  endtask

  task automatic update_model();
    bit to_boot;
    if (m_pend && m_pend_rd) m_ld_rdata = m_rdval;
    m_rdv = c_re;
    if (c_re) m_rdval = mem_rd(c_addr);
    if (c_we) exp_mem[int'(c_addr)] = c_wd;
    to_boot = (m_mode == "RUN") && boot_en && !m_boot_en_q;
    if (c_acc || to_boot) m_starve = 0;
    else if (m_mode == "RUN" && ld_req && !m_pend && c_cpu && m_starve < SMAX) m_starve++;
    if (c_cpu && cpu_rd && cpu_wr) m_proto = 1'b1;
    if (m_mode == "BOOT") begin
      if (boot_done) m_mode = "DRAIN";
    end else if (m_mode == "DRAIN") begin
      if (!c_acc) m_mode = "RELEASE";
    end else if (m_mode == "RELEASE") begin
      m_mode = "RUN";
    end else if (to_boot) begin
      m_mode = "BOOT";
    end
    m_pend = c_acc;
    if (c_acc) m_pend_rd = !ld_we;
    m_boot_en_q = boot_en;
  endtask

  // Inputs are driven at the falling edge; outputs are checked 1ns later
  task automatic step();
    #1;
    check_cycle();
    update_model();
    @(negedge clk);
  endtask

  task automatic ld_xfer(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit done;
    done = 1'b0;
    ld_req = 1'b1; ld_we = we; ld_addr = a; ld_wdata = d;
    for (int i = 0; i < 8 && !done; i++) begin
      done = m_pend;
      step();
    end
    chk("ld_xfer_done", 32'(done), 32'd1);
    ld_req = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_owner"},   32'(o_owner),      32'd0);
    chk({tag, "_ram_re"},  32'(o_ram_re),     32'd0);
    chk({tag, "_ram_we"},  32'(o_ram_we),     32'd0);
    chk({tag, "_addr"},    32'(o_ram_addr),   32'd0);
    chk({tag, "_wdata"},   32'(o_ram_wdata),  32'd0);
    chk({tag, "_ack"},     32'(o_ld_ack),     32'd0);
    chk({tag, "_rdata"},   32'(o_ld_rdata),   32'd0);
    chk({tag, "_cpu_rst"}, 32'(o_cpu_reset),  32'd1);
    chk({tag, "_starved"}, 32'(o_ld_starved), 32'd0);
    chk({tag, "_proto"},   32'(o_proto_err),  32'd0);
  endtask

  initial begin
    bit lr_active, ackd;
    int r;
    boot_en = 1'b0; boot_done = 1'b0; cpu_rd = 1'b0; cpu_wr = 1'b0;
    cpu_addr = 16'h0000; cpu_wdata = 16'h0000;
    ld_req = 1'b0; ld_we = 1'b0; ld_addr = 16'h0000; ld_wdata = 16'h0000;
    #1 rst_n = 1'b0;
    #3 check_reset_outputs("rst0");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // Boot: loader write then read-back while the CPU is held in reset
    ld_xfer(1'b1, 16'h0010, 16'hBEEF);
    ld_xfer(1'b0, 16'h0010, 16'h0000);
    chk("boot_rd_data", 32'(o_ld_rdata), 32'h0000BEEF);

    // boot_done aligned with a read accept: DRAIN, one RELEASE cycle, then RUN
    ld_req = 1'b1; ld_we = 1'b0; ld_addr = 16'h0010; boot_done = 1'b1;
    step();
    boot_done = 1'b0;
    step();
    ld_req = 1'b0;
    chk("release_cpu_reset", 32'(o_cpu_reset), 32'd1);
    step();
    chk("run_cpu_reset", 32'(o_cpu_reset), 32'd0);

    // CPU reads every cycle while the loader waits: starvation saturates
    cpu_rd = 1'b1; cpu_addr = 16'h0010;
    ld_req = 1'b1; ld_we = 1'b0; ld_addr = 16'h0010;
    repeat (300) step();
    chk("starved_set", 32'(o_ld_starved), 32'd1);
    cpu_rd = 1'b0;
    step();
    chk("starved_clear", 32'(o_ld_starved), 32'd0);
    chk("starved_ack", 32'(o_ld_ack), 32'd1);
    step();
    ld_req = 1'b0;

    // Simultaneous CPU read and write: write wins, protocol error sticks
    chk("proto_before", 32'(o_proto_err), 32'd0);
    cpu_rd = 1'b1; cpu_wr = 1'b1; cpu_addr = 16'h0020; cpu_wdata = 16'h1234;
    step();
    cpu_rd = 1'b0; cpu_wr = 1'b0;
    step();
    chk("proto_sticky", 32'(o_proto_err), 32'd1);
    ld_xfer(1'b0, 16'h0020, 16'h0000);
    chk("proto_wr_data", 32'(o_ld_rdata), 32'h00001234);

    // Random run-mode traffic with a well-behaved loader
    lr_active = 1'b0;
    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 19));
      cpu_rd    = (r < 5) || (r == 19);
      cpu_wr    = (r >= 5 && r < 9) || (r == 19);
      cpu_addr  = 16'($urandom_range(0, 63));
      cpu_wdata = 16'($urandom);
      if (!lr_active && $urandom_range(0, 2) == 0) begin
        lr_active = 1'b1; ld_req = 1'b1; ld_we = 1'($urandom_range(0, 1));
        ld_addr = 16'($urandom_range(0, 63)); ld_wdata = 16'($urandom);
      end
      ackd = m_pend;
      step();
      if (ackd) begin lr_active = 1'b0; ld_req = 1'b0; end
    end
    cpu_rd = 1'b0; cpu_wr = 1'b0;
    for (int i = 0; i < 4 && lr_active; i++) begin
      ackd = m_pend;
      step();
      if (ackd) begin lr_active = 1'b0; ld_req = 1'b0; end
    end
    chk("rand_drained", 32'(lr_active), 32'd0);

    // boot_en edge during a CPU write: the write lands, CPU reset follows
    cpu_wr = 1'b1; cpu_addr = 16'h0030; cpu_wdata = 16'h5A5A; boot_en = 1'b1;
    step();
    cpu_wr = 1'b0;
    chk("boot_en_cpu_reset", 32'(o_cpu_reset), 32'd1);
    ld_xfer(1'b0, 16'h0030, 16'h0000);
    chk("boot_en_wr_data", 32'(o_ld_rdata), 32'h00005A5A);
    boot_en = 1'b0;

    // Reset during a loader accept: no ack, no write, outputs at reset values
    ld_req = 1'b1; ld_we = 1'b1; ld_addr = 16'h0040; ld_wdata = 16'h7777;
    #1 chk("mid_owner", 32'(o_owner), 32'd2);
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("mid");
    @(negedge clk);
    check_reset_outputs("mid_hold");
    ld_req = 1'b0;
    rst_n  = 1'b1;
    model_reset();
    repeat (3) step();
    ld_xfer(1'b0, 16'h0040, 16'h0000);
    chk("mid_no_write", 32'(o_ld_rdata), 32'h00000000);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
